// File: rtl/mp_arbiter.sv
// Round-robin arbiter with burst hold sharing one multiplier among NREQ requesters.
// Optional per-requester grant counters enabled by defining MP_ARBITER_STATS_EN.
module mp_arbiter #(
  parameter int NREQ       = 3,
  parameter int MP_LATENCY = 2,
  parameter int BURST_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [24*NREQ-1:0]   mpcand_i,
  input  logic [16*NREQ-1:0]   mplier_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [23:0]          mpcand_o,
  output logic [15:0]          mplier_o,
  input  logic [23:0]          mprod_i,
  output logic [23:0]          prod_o,
  output logic [NREQ-1:0]      prod_valid_o
`ifdef MP_ARBITER_STATS_EN
  ,
  output logic [16*NREQ-1:0]   grant_cnt_o
`endif
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);

  logic [IDX_W-1:0] last_owner;
  logic [CNT_W-1:0] burst_cnt;
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;

  // burst_cnt of zero means the previous cycle was idle, so no owner is held
  always_comb begin : arb_search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    gnt_any  = 1'b0;
    gnt_idx  = last_owner;
    cand     = 0;
    cand_idx = '0;
    if (!rst) begin
      if ((burst_cnt != '0) && (burst_cnt < BURST_LIM) && req_i[last_owner]) begin
        gnt_any = 1'b1;
      end else begin
        for (int i = 1; i <= NREQ; i++) begin
          cand = int'(last_owner) + i;
          if (cand >= NREQ) cand = cand - NREQ;
          cand_idx = IDX_W'(cand);
          if (!gnt_any && req_i[cand_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = cand_idx;
          end
        end
      end
    end
  end

  assign gnt_o = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    mpcand_o = '0;
    mplier_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_o[k]) begin
        mpcand_o = mpcand_i[24*k +: 24];
        mplier_o = mplier_i[16*k +: 16];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= LAST_IDX;
      burst_cnt  <= '0;
    end else if (!gnt_any) begin
      burst_cnt <= '0;
    end else begin
      last_owner <= gnt_idx;
      if ((gnt_idx == last_owner) && (burst_cnt != '0)) begin
        if (burst_cnt < BURST_LIM) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= CNT_W'(1);
      end
    end
  end

  // ---- tag pipeline: grant travels alongside the multiplier latency ----
  logic [NREQ-1:0] vld_p [MP_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < MP_LATENCY; s++) vld_p[s] <= '0;
    end else begin
      vld_p[0] <= gnt_o;
      for (int s = 1; s < MP_LATENCY; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  assign prod_valid_o = rst ? '0 : vld_p[MP_LATENCY-1];
  assign prod_o       = mprod_i;

`ifdef MP_ARBITER_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++) grant_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (gnt_o[k] && (grant_cnt[k] != 16'hFFFF)) grant_cnt[k] <= grant_cnt[k] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt_out
    assign grant_cnt_o[16*g +: 16] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_mp_arbiter.sv
// Directed-vector bench for mp_arbiter (NREQ=3, MP_LATENCY=2, BURST_MAX=4).
module tb_mp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_i;
  logic [71:0] mpcand_i;
  logic [47:0] mplier_i;
  logic [2:0]  gnt_o;
  logic [23:0] mpcand_o;
  logic [15:0] mplier_o;
  logic [23:0] mprod_i;
  logic [23:0] prod_o;
  logic [2:0]  prod_valid_o;
`ifdef MP_ARBITER_STATS_EN
  logic [47:0] grant_cnt_o;
`endif

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  mp_arbiter #(.NREQ(3), .MP_LATENCY(2), .BURST_MAX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .mpcand_i     (mpcand_i),
    .mplier_i     (mplier_i),
    .gnt_o        (gnt_o),
    .mpcand_o     (mpcand_o),
    .mplier_o     (mplier_o),
    .mprod_i      (mprod_i),
    .prod_o       (prod_o),
    .prod_valid_o (prod_valid_o)
`ifdef MP_ARBITER_STATS_EN
    ,
    .grant_cnt_o  (grant_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] seq_a [9];
    logic [2:0] seq_b [4];
    seq_a = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
    seq_b = '{3'b100, 3'b100, 3'b100, 3'b001};

    rst      = 1'b1;
    req_i    = 3'b111;
    mpcand_i = {24'h555555, 24'h000100, 24'hAAAAAA};
    mplier_i = {16'h3333, 16'h0002, 16'h1111};
    mprod_i  = 24'h0;
    cyc();
    cyc();
    #1;
    chk("rst_gnt", 48'(gnt_o), 48'h0);
    chk("rst_mpcand", 48'(mpcand_o), 48'h0);
    chk("rst_mplier", 48'(mplier_o), 48'h0);
    chk("rst_pvld", 48'(prod_valid_o), 48'h0);
    cyc();

    // all three requesting: burst of 4 then rotate
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("rr_seq%0d", i), 48'(gnt_o), 48'(seq_a[i]));
      cyc();
    end

    // idle, then restart on requester 2 with burst count back at 1
    req_i = 3'b000;
    #1;
    chk("idle_gnt", 48'(gnt_o), 48'h0);
    chk("idle_mpcand", 48'(mpcand_o), 48'h0);
    chk("idle_mplier", 48'(mplier_o), 48'h0);
    cyc();
    req_i = 3'b100;
    #1;
    chk("restart_gnt", 48'(gnt_o), 48'h4);
    cyc();
    req_i = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("restart_seq%0d", i), 48'(gnt_o), 48'(seq_b[i]));
      cyc();
    end

    // single-cycle request from 1 with operand routing and 2-cycle tag
    req_i   = 3'b010;
    mprod_i = 24'h000200;
    #1;
    chk("op_gnt", 48'(gnt_o), 48'h2);
    chk("op_mpcand", 48'(mpcand_o), 48'h000100);
    chk("op_mplier", 48'(mplier_o), 48'h0002);
    chk("op_prod", 48'(prod_o), 48'h000200);
    cyc();
    req_i = 3'b000;
    #1;
    chk("pvld_prev", 48'(prod_valid_o), 48'h1);
    cyc();
    #1;
    chk("pvld_op", 48'(prod_valid_o), 48'h2);
    cyc();
    #1;
    chk("pvld_idle", 48'(prod_valid_o), 48'h0);
    cyc();

    // lone requester never stalls at the burst limit
    req_i = 3'b001;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("solo%0d", i), 48'(gnt_o), 48'h1);
      cyc();
    end

    // grant to 2, then reset flushes in-flight tags
    req_i = 3'b100;
    #1;
    chk("pre_rst_gnt", 48'(gnt_o), 48'h4);
    cyc();
    rst   = 1'b1;
    req_i = 3'b111;
    #1;
    chk("mid_rst_gnt", 48'(gnt_o), 48'h0);
    chk("mid_rst_pvld", 48'(prod_valid_o), 48'h0);
    cyc();
    rst   = 1'b0;
    req_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("flush%0d", i), 48'(prod_valid_o), 48'h0);
      cyc();
    end
    req_i = 3'b111;
    #1;
    chk("post_rst_gnt", 48'(gnt_o), 48'h1);
    cyc();

`ifdef MP_ARBITER_STATS_EN
    rst   = 1'b1;
    req_i = 3'b000;
    cyc();
    rst   = 1'b0;
    req_i = 3'b001;
    for (int i = 0; i < 70000; i++) cyc();
    req_i = 3'b000;
    #1;
    chk("cnt0_sat", grant_cnt_o[15:0], 48'hFFFF);
    chk("cnt1", grant_cnt_o[31:16], 48'h0);
    chk("cnt2", grant_cnt_o[47:32], 48'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
